// File: rtl/bowling_frame_ctrl.sv
// Bowling game sequencer: frame/ball schedule, target-lane LFSR, throw
// handshake, and score accumulation with strike/spare bonuses.
module bowling_frame_ctrl #(
  parameter int         NUM_FRAMES = 10,
  parameter int         NUM_PINS   = 10,
  parameter logic [2:0] LFSR_SEED  = 3'b001
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       throw_valid,
  input  logic [3:0] pins_hit,
  output logic       throw_ready,
  output logic [2:0] target,
  output logic [3:0] frame_num,
  output logic       ball_num,
  output logic [3:0] pins_standing,
  output logic [8:0] score,
  output logic       strike,
  output logic       spare,
  output logic       round_reset,
  output logic       game_over
);

  localparam logic [3:0] PINS_FULL  = 4'(NUM_PINS);
  localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    NEW_BALL   = 3'd1,
    WAIT_THROW = 3'd2,
    SCORE      = 3'd3,
    FRAME_END  = 3'd4,
    GAME_OVER  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] lfsr_q, lfsr_d;
  logic [2:0] target_q, target_d;
  logic [3:0] frame_q, frame_d;
  logic       ball_q, ball_d;
  logic [3:0] pins_q, pins_d;
  logic [3:0] p_q, p_d;
  logic [8:0] score_q, score_d;
  logic [1:0] b1_q, b1_d;
  logic       b2_q, b2_d;
  logic       strike_q, strike_d;
  logic       spare_q, spare_d;
  logic       rr_q, rr_d;

  logic [2:0] lfsr_nxt;
  logic [3:0] hit_clamp;
  logic       clear_all;
  logic       bonus_en;
  logic       is_strike;
  logic       is_spare;

  // Fibonacci step for x^3+x^2+1.
  function automatic logic [2:0] lfsr_step(input logic [2:0] q);
    return {q[1:0], q[2] ^ q[1]};
  endfunction

  // Adds p weighted by (1+b1) and clamps the 9-bit total at 511.
  function automatic logic [8:0] score_sat(input logic [8:0] s,
                                           input logic [3:0] p,
                                           input logic [1:0] b1);
    logic [9:0] inc;
    logic [9:0] sum;
    inc = 10'(p) * (10'(b1) + 10'd1);
    sum = {1'b0, s} + inc;
    return sum[9] ? 9'h1FF : sum[8:0];
  endfunction

  // Next-state and datapath updates for the game schedule.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    target_d  = target_q;
    frame_d   = frame_q;
    ball_d    = ball_q;
    pins_d    = pins_q;
    p_d       = p_q;
    score_d   = score_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    strike_d  = 1'b0;
    spare_d   = 1'b0;
    rr_d      = 1'b0;
    lfsr_nxt  = lfsr_step(lfsr_q);
    hit_clamp = (pins_hit > pins_q) ? pins_q : pins_hit;
    clear_all = (p_q == pins_q);
    bonus_en  = (frame_q != LAST_FRAME);
    is_strike = ~ball_q & clear_all;
    is_spare  = ball_q & clear_all;

    case (state_q)
      IDLE: begin
        if (start) state_d = NEW_BALL;
      end
      NEW_BALL: begin
        lfsr_d   = lfsr_nxt;
        target_d = {1'b0, lfsr_nxt[1:0]} + 3'd1;
        state_d  = WAIT_THROW;
      end
      WAIT_THROW: begin
        if (throw_valid) begin
          p_d     = hit_clamp;
          state_d = SCORE;
        end
      end
      SCORE: begin
        score_d = score_sat(score_q, p_q, b1_q);
        b1_d    = {1'b0, b2_q} + {1'b0, is_strike & bonus_en}
                + {1'b0, is_spare & bonus_en};
        b2_d    = is_strike & bonus_en;
        if (is_strike) begin
          strike_d = 1'b1;
          state_d  = FRAME_END;
        end else if (is_spare) begin
          spare_d = 1'b1;
          state_d = FRAME_END;
        end else if (ball_q) begin
          state_d = FRAME_END;
        end else begin
          pins_d  = pins_q - p_q;
          ball_d  = 1'b1;
          state_d = NEW_BALL;
        end
      end
      FRAME_END: begin
        rr_d   = 1'b1;
        pins_d = PINS_FULL;
        ball_d = 1'b0;
        if (frame_q == LAST_FRAME) begin
          state_d = GAME_OVER;
        end else begin
          frame_d = frame_q + 4'd1;
          state_d = NEW_BALL;
        end
      end
      GAME_OVER: begin
        if (start) begin
          score_d = '0;
          b1_d    = '0;
          b2_d    = 1'b0;
          frame_d = 4'd1;
          ball_d  = 1'b0;
          pins_d  = PINS_FULL;
          state_d = NEW_BALL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      target_q <= 3'd1;
      frame_q  <= 4'd1;
      ball_q   <= 1'b0;
      pins_q   <= PINS_FULL;
      p_q      <= '0;
      score_q  <= '0;
      b1_q     <= '0;
      b2_q     <= 1'b0;
      strike_q <= 1'b0;
      spare_q  <= 1'b0;
      rr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      frame_q  <= frame_d;
      ball_q   <= ball_d;
      pins_q   <= pins_d;
      p_q      <= p_d;
      score_q  <= score_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      strike_q <= strike_d;
      spare_q  <= spare_d;
      rr_q     <= rr_d;
    end
  end

  assign throw_ready   = (state_q == WAIT_THROW);
  assign game_over     = (state_q == GAME_OVER);
  assign target        = target_q;
  assign frame_num     = frame_q;
  assign ball_num      = ball_q;
  assign pins_standing = pins_q;
  assign score         = score_q;
  assign strike        = strike_q;
  assign spare         = spare_q;
  assign round_reset   = rr_q;

endmodule

// File: tb/tb_bowling_frame_ctrl.sv
// Scoreboard bench for bowling_frame_ctrl: directed throws with hand-computed
// scores; a monitor checks the DUT each time it settles into WAIT_THROW or
// GAME_OVER.
module tb_bowling_frame_ctrl;

  logic       CLOCK_50;
  logic       resetn;
  logic       start;
  logic       throw_valid;
  logic [3:0] pins_hit;
  logic       throw_ready;
  logic [2:0] target;
  logic [3:0] frame_num;
  logic       ball_num;
  logic [3:0] pins_standing;
  logic [8:0] score;
  logic       strike;
  logic       spare;
  logic       round_reset;
  logic       game_over;

  bowling_frame_ctrl #(.NUM_FRAMES(10), .NUM_PINS(10), .LFSR_SEED(3'b001)) dut (
    .CLOCK_50      (CLOCK_50),
    .resetn        (resetn),
    .start         (start),
    .throw_valid   (throw_valid),
    .pins_hit      (pins_hit),
    .throw_ready   (throw_ready),
    .target        (target),
    .frame_num     (frame_num),
    .ball_num      (ball_num),
    .pins_standing (pins_standing),
    .score         (score),
    .strike        (strike),
    .spare         (spare),
    .round_reset   (round_reset),
    .game_over     (game_over)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int score;
    int frame;
    int ball;
    int pins;
    int target;
    int s;
    int sp;
    int rr;
    int go;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   rr_total;

  // Bookkeeping model (frame/ball/pins/target); scores come from the vectors.
  int         m_frame;
  int         m_ball;
  int         m_pins;
  int         m_target;
  logic [2:0] m_lfsr;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic m_advance();
    m_lfsr   = {m_lfsr[1:0], m_lfsr[2] ^ m_lfsr[1]};
    m_target = int'(m_lfsr[1:0]) + 1;
  endtask

  task automatic m_newgame();
    m_frame = 1;
    m_ball  = 0;
    m_pins  = 10;
  endtask

  // Monitor: accumulate pulses, compare against the queue at each settle point.
  initial begin
    int   acc_s, acc_sp, acc_rr;
    logic prev_rdy, prev_go;
    exp_t e;
    acc_s = 0; acc_sp = 0; acc_rr = 0; prev_rdy = 1'b0; prev_go = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (!resetn) begin
        acc_s = 0; acc_sp = 0; acc_rr = 0; prev_rdy = 1'b0; prev_go = 1'b0;
      end else begin
        acc_s    += int'(strike);
        acc_sp   += int'(spare);
        acc_rr   += int'(round_reset);
        rr_total += int'(round_reset);
        if ((throw_ready && !prev_rdy) || (game_over && !prev_go)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_settle", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("score",         int'(score),         e.score);
            chk("frame_num",     int'(frame_num),     e.frame);
            chk("ball_num",      int'(ball_num),      e.ball);
            chk("pins_standing", int'(pins_standing), e.pins);
            chk("target",        int'(target),        e.target);
            chk("strike_pulses", acc_s,               e.s);
            chk("spare_pulses",  acc_sp,              e.sp);
            chk("rr_pulses",     acc_rr,              e.rr);
            chk("game_over",     int'(game_over),     e.go);
          end
          acc_s = 0; acc_sp = 0; acc_rr = 0;
        end
        prev_rdy = throw_ready;
        prev_go  = game_over;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_throw_ready"}, int'(throw_ready),   0);
    chk({tag, "_target"},      int'(target),        1);
    chk({tag, "_frame"},       int'(frame_num),     1);
    chk({tag, "_ball"},        int'(ball_num),      0);
    chk({tag, "_pins"},        int'(pins_standing), 10);
    chk({tag, "_score"},       int'(score),         0);
    chk({tag, "_pulses"},      int'(strike) + int'(spare) + int'(round_reset), 0);
    chk({tag, "_game_over"},   int'(game_over),     0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    check_reset_vals(tag);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    exp_q.delete();
    m_lfsr   = 3'b001;
    m_target = 1;
    m_newgame();
  endtask

  task automatic do_start();
    exp_t e;
    m_newgame();
    m_advance();
    e = '{score: 0, frame: 1, ball: 0, pins: 10, target: m_target,
          s: 0, sp: 0, rr: 0, go: 0};
    exp_q.push_back(e);
    @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  // One throw: wait for ready, drive the pulse, push the expected settle state.
  task automatic do_throw(input int hit, input int exp_score,
                          input int exp_s, input int exp_sp);
    int   w, p;
    logic endf, last;
    exp_t e;
    w = 0;
    while (!throw_ready && w < 50) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (!throw_ready) begin
      chk("ready_timeout", int'(throw_ready), 1);
      return;
    end
    p    = (hit > m_pins) ? m_pins : hit;
    last = (m_frame == 10);
    endf = (p == m_pins) || (m_ball == 1);
    if (endf) begin
      m_pins = 10;
      m_ball = 0;
      if (!last) begin
        m_frame++;
        m_advance();
      end
    end else begin
      m_pins -= p;
      m_ball  = 1;
      m_advance();
    end
    e = '{score: exp_score, frame: m_frame, ball: m_ball, pins: m_pins,
          target: m_target, s: exp_s, sp: exp_sp, rr: int'(endf),
          go: int'(endf && last)};
    exp_q.push_back(e);
    throw_valid = 1'b1;
    pins_hit    = 4'(hit);
    @(negedge CLOCK_50);
    throw_valid = 1'b0;
    pins_hit    = 4'd0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge CLOCK_50);
      w++;
    end
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; rr_total = 0;
    resetn = 1'b0; start = 1'b0; throw_valid = 1'b0; pins_hit = 4'd0;
    m_lfsr = 3'b001; m_target = 1;
    m_newgame();
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;

    // Full game of 4/4 open frames.
    do_reset("rst0");
    check_reset_vals("idle");
    do_start();
    rr_total = 0;
    for (int i = 0; i < 20; i++) do_throw(4, 4 * (i + 1), 0, 0);
    drain("open");
    chk("open_rr_total", rr_total, 10);
    repeat (3) @(negedge CLOCK_50);
    chk("hold_game_over", int'(game_over), 1);
    chk("hold_frame", int'(frame_num), 10);
    chk("hold_score", int'(score), 80);

    // Restart from GAME_OVER (LFSR continues): strike then 3, 4.
    do_start();
    do_throw(10, 10, 1, 0);
    do_throw(3, 16, 0, 0);
    do_throw(4, 24, 0, 0);
    drain("strike");

    // Spare then 5, 0.
    do_reset("rst1");
    do_start();
    do_throw(6, 6, 0, 0);
    do_throw(4, 10, 0, 1);
    do_throw(5, 20, 0, 0);
    do_throw(0, 20, 0, 0);
    drain("spare");

    // Three strikes, then 0 and 0.
    do_reset("rst2");
    do_start();
    do_throw(10, 10, 1, 0);
    do_throw(10, 30, 1, 0);
    do_throw(10, 60, 1, 0);
    do_throw(0, 60, 0, 0);
    do_throw(0, 60, 0, 0);
    drain("turkey");

    // Clamping: 15 on ball 0, then 7 and 9 with 3 standing.
    do_reset("rst3");
    do_start();
    do_throw(15, 10, 1, 0);
    do_throw(7, 24, 0, 0);
    do_throw(9, 30, 0, 1);
    drain("clamp");

    // Reset in WAIT_THROW of frame 5, then throws with no start.
    do_reset("rst4");
    do_start();
    for (int i = 0; i < 8; i++) do_throw(0, 0, 0, 0);
    drain("mid");
    chk("mid_frame", int'(frame_num), 5);
    chk("mid_ready", int'(throw_ready), 1);
    do_reset("midrst");
    for (int i = 0; i < 2; i++) begin
      throw_valid = 1'b1;
      pins_hit    = 4'd5;
      @(negedge CLOCK_50);
      throw_valid = 1'b0;
      pins_hit    = 4'd0;
      @(negedge CLOCK_50);
    end
    repeat (6) @(negedge CLOCK_50);
    check_reset_vals("after_ignored");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bowling_frame_ctrl.md
Name: bowling_frame_ctrl

Overview:
- Game sequencer for the bowling datapath. Runs the frame/ball schedule, picks a pseudo-random target lane for each ball, and hands throw opportunities to the throw datapath through a ready/valid handshake.
- Accumulates the score, including strike and spare bonuses, and signals frame end and game over to the display and round-reset logic.
- Replaces the ad-hoc hit/miss counting with one clocked controller.

Parameters:
- NUM_FRAMES, 10, frames per game.
- NUM_PINS, 10, pins racked at the start of each frame.
- LFSR_SEED, 3'b001, reset value of the 3-bit target LFSR; must be nonzero.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a game; accepted in IDLE and GAME_OVER only.
- throw_valid  in  1  single-cycle pulse from the datapath: a throw result is present.
- pins_hit  in  4  pins knocked down by this throw; sampled only with throw_valid.
- throw_ready  out  1  high only in WAIT_THROW.
- target  out  3  current target lane, range 1..4.
- frame_num  out  4  current frame, range 1..NUM_FRAMES.
- ball_num  out  1  0 = first ball of the frame, 1 = second ball.
- pins_standing  out  4  pins remaining in the frame.
- score  out  9  running game total.
- strike  out  1  one-cycle pulse on a strike.
- spare  out  1  one-cycle pulse on a spare.
- round_reset  out  1  one-cycle pulse at the end of each frame.
- game_over  out  1  level; high in GAME_OVER.

Behaviour:
- Reset (asynchronous, resetn=0). Entered immediately, mid-game included; any throw in flight is discarded. Values:
  - state=IDLE
  - LFSR=LFSR_SEED, target=1
  - frame_num=1, ball_num=0, pins_standing=NUM_PINS
  - score=0, both bonus counters=0
  - all pulse outputs=0, throw_ready=0, game_over=0
- LFSR: Fibonacci, taps x^3+x^2+1 (next = {q[1:0], q[2]^q[1]}). It advances only in NEW_BALL, and target is registered as (next LFSR mod 4)+1.
- States:
  - IDLE: wait for start; then go to NEW_BALL.
  - NEW_BALL: one cycle. Advance the LFSR, latch target, go to WAIT_THROW.
  - WAIT_THROW: throw_ready=1. On throw_valid, latch p = min(pins_hit, pins_standing) and go to SCORE. throw_valid in any other state is ignored; start is ignored here.
  - SCORE: one cycle. Compute and apply in the order below, then go to FRAME_END or NEW_BALL.
    1. score += p*(1+b1). b1 is 0..2, so the increment is at most 30. Arithmetic is 9-bit and saturates at 511.
    2. Shift bonuses: b1 <= b2 + s + sp, b2 <= s. s=1 on a strike, sp=1 on a spare. Bonus generation (s and sp) is forced to 0 when frame_num==NUM_FRAMES; no fill balls are thrown.
    3. Strike: ball_num==0 and p==pins_standing. Pulse strike and go to FRAME_END.
    4. Spare: ball_num==1 and p==pins_standing. Pulse spare and go to FRAME_END.
    5. Otherwise: ball_num==1 goes to FRAME_END. ball_num==0 sets pins_standing -= p, ball_num=1, and goes to NEW_BALL.
  - FRAME_END: one cycle. Pulse round_reset, set pins_standing=NUM_PINS and ball_num=0.
    - If frame_num==NUM_FRAMES, go to GAME_OVER; frame_num holds.
    - Otherwise frame_num++ and go to NEW_BALL.
  - GAME_OVER: game_over=1; score, frame_num and target hold. On start: score=0, b1=b2=0, frame_num=1, ball_num=0, pins_standing=NUM_PINS, go to NEW_BALL. The LFSR is not reseeded.
- Latency: at least 4 cycles from a throw_valid that ends a frame to the next throw_ready (SCORE, FRAME_END, NEW_BALL, then WAIT_THROW), and 3 cycles within a frame.
- Zero-pin throw: a legal throw. On the first ball it is not a strike, even if pins_standing were 0, because pins_standing is always NUM_PINS on ball 0.
- pins_hit greater than pins_standing is clamped; it never underflows.

Test Plan:
- Reset, start, then 20 throws of 4 pins → each frame a 4/4 open frame; 10 round_reset pulses; score=80; game_over=1; frame_num=10.
- Frame 1 strike (10), frame 2 throws 3 then 4 → strike pulse in frame 1; score sequence 10, 16, 24 (3 and 4 each doubled).
- Frame 1 throws 6 then 4 (spare), frame 2 throws 5 then 0 → spare pulse; score 6, 10, 20, 20.
- Three consecutive strikes in frames 1–3, then frame 4 throws 0 and 0 → score 10, 30, 60, 60 (b1=2 on the third strike).
- pins_hit=15 on the first ball → clamped to 10, counted as a strike; pins_hit=9 on the second ball with 3 standing → clamped to 3, counted as a spare.
- Pulse resetn low in WAIT_THROW of frame 5, then pulse throw_valid with no start → outputs at reset values; throw_ready=0; score stays 0.
